// File: rtl/e203_icb_pkg.sv
// ---------------------------------------------------------------------------
// e203_icb_pkg
// Shared ICB definitions: data/mask widths and the packed response word that
// travels from the memory read port, through the delay line, into the
// response FIFO and out to the initiator.
// ---------------------------------------------------------------------------
package e203_icb_pkg;

    localparam int ICB_DW = 32;
    localparam int ICB_MW = ICB_DW / 8;

    typedef struct packed {
        logic              err;
        logic [ICB_DW-1:0] rdata;
    } icb_rsp_t;

endpackage : e203_icb_pkg

// File: rtl/e203_icb_rsp_fifo.sv
// ---------------------------------------------------------------------------
// e203_icb_rsp_fifo
// Small in-order FIFO holding completed ICB responses.
//   clk, rst_n  : clock, asynchronous active-low reset (clears pointers/count)
//   push        : write push_data into the tail (ignored when full)
//   push_data   : response entry to enqueue
//   pop         : drop the head entry (ignored when empty)
//   pop_data    : head entry, valid while empty = 0
//   full, empty : occupancy flags
// Entry storage is not reset; only the bookkeeping is.
// ---------------------------------------------------------------------------
module e203_icb_rsp_fifo
    import e203_icb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  icb_rsp_t push_data,
    input  logic     pop,
    output icb_rsp_t pop_data,
    output logic     full,
    output logic     empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    icb_rsp_t        mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem_q[rd_ptr_q];

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule : e203_icb_rsp_fifo

// File: rtl/e203_mem_icb_resp.sv
// ---------------------------------------------------------------------------
// e203_mem_icb_resp
// ICB slave in front of a word-addressed register-array memory window.
//   clk, rst_n      : clock, asynchronous active-low reset
//   icb_cmd_*       : command channel (valid/ready, addr, read, wdata, wmask)
//   icb_rsp_*       : response channel (valid/ready, err, rdata)
//
// Handshake rule (both channels): a transfer happens on a rising edge where
// valid and ready are both 1; the sender holds its payload stable until then,
// and ready never depends combinationally on the other channel.
//
// Flow: a command is decoded and the memory accessed at its handshake edge.
// The resulting {err, rdata} goes through LATENCY-1 register stages, then
// into the response FIFO, whose head drives the response channel. Limiting
// outstanding commands to OUTS (= FIFO depth) means the FIFO always has room
// for every response still in the delay line.
// ---------------------------------------------------------------------------
module e203_mem_icb_resp
    import e203_icb_pkg::*;
#(
    parameter int            AW        = 32,
    parameter logic [AW-1:0] MEM_BASE  = 32'h8000_0000,
    parameter int            MEM_WORDS = 1024,
    parameter int            LATENCY   = 1,
    parameter int            OUTS      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icb_cmd_valid,
    output logic              icb_cmd_ready,
    input  logic [AW-1:0]     icb_cmd_addr,
    input  logic              icb_cmd_read,
    input  logic [ICB_DW-1:0] icb_cmd_wdata,
    input  logic [ICB_MW-1:0] icb_cmd_wmask,
    output logic              icb_rsp_valid,
    input  logic              icb_rsp_ready,
    output logic              icb_rsp_err,
    output logic [ICB_DW-1:0] icb_rsp_rdata
);

    localparam int            IW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int            CW        = $clog2(OUTS + 1);
    localparam logic [AW-1:0] WIN_BYTES = AW'(4 * MEM_WORDS);

    logic              cmd_hs, rsp_hs;
    logic [AW-1:0]     addr_off;
    logic              cmd_err;
    logic [IW-1:0]     word_idx;
    icb_rsp_t          cmd_rsp;
    logic [CW-1:0]     outs_q, outs_d;
    logic              fifo_push, fifo_full, fifo_empty;
    icb_rsp_t          fifo_push_data, fifo_head;
    logic [ICB_DW-1:0] mem_q [MEM_WORDS];

    assign cmd_hs = icb_cmd_valid & icb_cmd_ready;
    assign rsp_hs = icb_rsp_valid & icb_rsp_ready;

    // Ready comes from the registered counter only.
    assign icb_cmd_ready = (outs_q < CW'(OUTS));

    // ---------------- address decode ----------------
    // Offset arithmetic wraps below MEM_BASE, so the lower bound is checked
    // separately from the window size.
    assign addr_off = icb_cmd_addr - MEM_BASE;
    assign cmd_err  = (icb_cmd_addr[1:0] != 2'b00)
                    | (icb_cmd_addr < MEM_BASE)
                    | (addr_off >= WIN_BYTES);
    assign word_idx = addr_off[IW+1:2];

    // Read sees the word as stored before this edge; writes and errors
    // return zero data.
    always_comb begin
        cmd_rsp.err   = cmd_err;
        cmd_rsp.rdata = '0;
        if (!cmd_err && icb_cmd_read) begin
            cmd_rsp.rdata = mem_q[word_idx];
        end
    end

    // ---------------- storage (not reset) ----------------
    always_ff @(posedge clk) begin
        if (cmd_hs && !icb_cmd_read && !cmd_err) begin
            for (int i = 0; i < ICB_MW; i++) begin
                if (icb_cmd_wmask[i]) begin
                    mem_q[word_idx][8*i +: 8] <= icb_cmd_wdata[8*i +: 8];
                end
            end
        end
    end

    // ---------------- outstanding counter ----------------
    always_comb begin
        outs_d = outs_q;
        if (cmd_hs && !rsp_hs) begin
            outs_d = outs_q + 1'b1;
        end else if (!cmd_hs && rsp_hs) begin
            outs_d = outs_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outs_q <= '0;
        end else begin
            outs_q <= outs_d;
        end
    end

    // ---------------- response delay line ----------------
    // LATENCY = 1 pushes straight into the FIFO at the handshake edge, so the
    // response is visible the next cycle.
    if (LATENCY > 1) begin : g_delay
        localparam int NS = LATENCY - 1;

        logic [NS-1:0] dl_vld_q, dl_vld_d;
        icb_rsp_t      dl_data_q [NS];
        icb_rsp_t      dl_data_d [NS];

        always_comb begin
            dl_vld_d[0]  = cmd_hs;
            dl_data_d[0] = cmd_rsp;
            for (int i = 1; i < NS; i++) begin
                dl_vld_d[i]  = dl_vld_q[i-1];
                dl_data_d[i] = dl_data_q[i-1];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dl_vld_q <= '0;
            end else begin
                dl_vld_q <= dl_vld_d;
            end
        end

        always_ff @(posedge clk) begin
            for (int i = 0; i < NS; i++) begin
                dl_data_q[i] <= dl_data_d[i];
            end
        end

        assign fifo_push      = dl_vld_q[NS-1] & ~fifo_full;
        assign fifo_push_data = dl_data_q[NS-1];
    end else begin : g_direct
        assign fifo_push      = cmd_hs & ~fifo_full;
        assign fifo_push_data = cmd_rsp;
    end

    // ---------------- response FIFO ----------------
    e203_icb_rsp_fifo #(
        .DEPTH (OUTS)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (rsp_hs),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Gate the payload with valid so an idle or resetting port shows zeros
    // even though FIFO storage itself is never cleared.
    assign icb_rsp_valid = ~fifo_empty;
    assign icb_rsp_err   = icb_rsp_valid & fifo_head.err;
    assign icb_rsp_rdata = icb_rsp_valid ? fifo_head.rdata : '0;

endmodule : e203_mem_icb_resp

// File: tb/tb_e203_mem_icb_resp.sv
// ---------------------------------------------------------------------------
// tb_e203_mem_icb_resp
// Directed bench for e203_mem_icb_resp with LATENCY = 1, OUTS = 2.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_e203_mem_icb_resp;

    localparam int LAT  = 1;
    localparam int OUTS = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic        icb_rsp_err;
    logic [31:0] icb_rsp_rdata;

    e203_mem_icb_resp #(
        .AW        (32),
        .MEM_BASE  (32'h8000_0000),
        .MEM_WORDS (1024),
        .LATENCY   (LAT),
        .OUTS      (OUTS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_err   (icb_rsp_err),
        .icb_rsp_rdata (icb_rsp_rdata)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] wm);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (wm[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_cmd();
        icb_cmd_addr  = $urandom;
        icb_cmd_read  = 1'($urandom_range(0, 1));
        icb_cmd_wdata = $urandom;
        icb_cmd_wmask = 4'($urandom_range(0, 15));
    endtask

    // One isolated command with rsp_ready = 1; checks latency and payload.
    task automatic single(input string tag, input logic [31:0] addr, input logic rd,
                          input logic [31:0] wd, input logic [3:0] wm,
                          input logic exp_err, input logic [31:0] exp_rdata);
        icb_cmd_valid = 1'b1;
        icb_cmd_addr  = addr;
        icb_cmd_read  = rd;
        icb_cmd_wdata = wd;
        icb_cmd_wmask = wm;
        check({tag, "_cmd_ready"}, 32'(icb_cmd_ready), 32'd1);
        check({tag, "_idle"}, 32'(icb_rsp_valid), 32'd0);
        tick();
        icb_cmd_valid = 1'b0;
        scramble_cmd();
        for (int i = 1; i < LAT; i++) begin
            check({tag, "_early"}, 32'(icb_rsp_valid), 32'd0);
            tick();
        end
        check({tag, "_rsp_valid"}, 32'(icb_rsp_valid), 32'd1);
        check({tag, "_err"}, 32'(icb_rsp_err), 32'(exp_err));
        check({tag, "_rdata"}, icb_rsp_rdata, exp_rdata);
        tick();
        check({tag, "_drained"}, 32'(icb_rsp_valid), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] w10;
    logic [31:0] bp_data [3];
    logic [31:0] strm [16];

    initial begin
        icb_cmd_valid = 1'b0;
        icb_rsp_ready = 1'b1;
        scramble_cmd();

        // Reset state
        #1;
        check("rst_cmd_ready", 32'(icb_cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(icb_rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(icb_rsp_err), 32'd0);
        check("rst_rsp_rdata", icb_rsp_rdata, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Full-word write then read back
        w10 = merge(32'h0, 32'hDEAD_BEEF, 4'hF);
        single("wr_full", 32'h8000_0010, 1'b0, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0);
        single("rd_full", 32'h8000_0010, 1'b1, 32'h0, 4'h0, 1'b0, w10);

        // Single byte-lane write (byte 1)
        w10 = merge(w10, 32'h0000_AA00, 4'b0010);
        single("wr_lane1", 32'h8000_0010, 1'b0, 32'h0000_AA00, 4'b0010, 1'b0, 32'h0);
        single("rd_lane1", 32'h8000_0010, 1'b1, 32'h0, 4'h0, 1'b0, w10);

        // Empty mask: completes, no change
        single("wr_nomask", 32'h8000_0010, 1'b0, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0);
        single("rd_nomask", 32'h8000_0010, 1'b1, 32'h0, 4'h0, 1'b0, w10);

        // Error cases: misaligned, out of window, writes to bad addresses
        single("rd_misal", 32'h8000_0012, 1'b1, 32'h0, 4'h0, 1'b1, 32'h0);
        single("rd_oow", 32'h9000_0000, 1'b1, 32'h0, 4'h0, 1'b1, 32'h0);
        single("wr_misal", 32'h8000_0011, 1'b0, 32'h1111_1111, 4'hF, 1'b1, 32'h0);
        single("wr_oow", 32'h8000_1000, 1'b0, 32'h2222_2222, 4'hF, 1'b1, 32'h0);
        single("rd_after_err", 32'h8000_0010, 1'b1, 32'h0, 4'h0, 1'b0, w10);

        // Window boundaries
        single("wr_last", 32'h8000_0FFC, 1'b0, 32'h1234_5678, 4'hF, 1'b0, 32'h0);
        single("rd_last", 32'h8000_0FFC, 1'b1, 32'h0, 4'h0, 1'b0, 32'h1234_5678);
        single("rd_past_end", 32'h8000_1000, 1'b1, 32'h0, 4'h0, 1'b1, 32'h0);
        single("rd_below", 32'h7FFF_FFFC, 1'b1, 32'h0, 4'h0, 1'b1, 32'h0);

        // Write immediately followed by read of the same word
        icb_cmd_valid = 1'b1;
        icb_cmd_addr  = 32'h8000_0014;
        icb_cmd_read  = 1'b0;
        icb_cmd_wdata = 32'h55AA_55AA;
        icb_cmd_wmask = 4'hF;
        tick();
        icb_cmd_read  = 1'b1;
        icb_cmd_wdata = 32'h0;
        check("raw_cmd_ready", 32'(icb_cmd_ready), 32'd1);
        check("raw_wr_rdata", icb_rsp_rdata, 32'h0);
        tick();
        icb_cmd_valid = 1'b0;
        check("raw_rd_valid", 32'(icb_rsp_valid), 32'd1);
        check("raw_rd_rdata", icb_rsp_rdata, 32'h55AA_55AA);
        tick();
        check("raw_drained", 32'(icb_rsp_valid), 32'd0);

        // Backpressure: three back-to-back reads with rsp_ready low
        for (int i = 0; i < 3; i++) begin
            bp_data[i] = 32'hA0A0_0000 | 32'(i * 17);
            single("bp_prefill", 32'h8000_0020 + 32'(4 * i), 1'b0, bp_data[i], 4'hF, 1'b0, 32'h0);
        end
        icb_rsp_ready = 1'b0;
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = 1'b1;
        icb_cmd_addr  = 32'h8000_0020;
        check("bp_rdy0", 32'(icb_cmd_ready), 32'd1);
        tick();
        icb_cmd_addr = 32'h8000_0024;
        check("bp_rdy1", 32'(icb_cmd_ready), 32'd1);
        check("bp_valid1", 32'(icb_rsp_valid), 32'd1);
        tick();
        icb_cmd_addr = 32'h8000_0028;
        for (int i = 0; i < 3; i++) begin
            check("bp_stall_rdy", 32'(icb_cmd_ready), 32'd0);
            check("bp_hold_valid", 32'(icb_rsp_valid), 32'd1);
            check("bp_hold_err", 32'(icb_rsp_err), 32'd0);
            check("bp_hold_rdata", icb_rsp_rdata, bp_data[0]);
            tick();
        end
        icb_rsp_ready = 1'b1;
        #1;
        check("bp_no_comb_path", 32'(icb_cmd_ready), 32'd0);
        tick();
        check("bp_rsp1", icb_rsp_rdata, bp_data[1]);
        check("bp_rdy_back", 32'(icb_cmd_ready), 32'd1);
        tick();
        icb_cmd_valid = 1'b0;
        scramble_cmd();
        check("bp_rsp2_valid", 32'(icb_rsp_valid), 32'd1);
        check("bp_rsp2", icb_rsp_rdata, bp_data[2]);
        tick();
        check("bp_drained", 32'(icb_rsp_valid), 32'd0);

        // Streaming: 16 back-to-back reads, rsp_ready held high
        for (int i = 0; i < 16; i++) begin
            strm[i] = 32'hC0DE_0000 | 32'((i * 32'h0123) & 32'hFFFF);
            single("st_prefill", 32'h8000_0100 + 32'(4 * i), 1'b0, strm[i], 4'hF, 1'b0, 32'h0);
        end
        begin
            int issued, got, cyc, stalls, first_rsp, last_rsp;
            issued = 0; got = 0; cyc = 0; stalls = 0; first_rsp = -1; last_rsp = -1;
            icb_cmd_valid = 1'b1;
            icb_cmd_read  = 1'b1;
            icb_cmd_addr  = 32'h8000_0100;
            while ((issued < 16 || got < 16) && cyc < 40) begin
                if (icb_cmd_valid) begin
                    if (icb_cmd_ready) begin
                        exp_q.push_back(strm[issued]);
                        issued++;
                    end else begin
                        stalls++;
                    end
                end
                if (icb_rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        check("st_unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        check("st_rdata", icb_rsp_rdata, exp_q.pop_front());
                    end
                    if (first_rsp < 0) first_rsp = cyc;
                    last_rsp = cyc;
                    got++;
                end
                tick();
                cyc++;
                if (issued < 16) begin
                    icb_cmd_addr = 32'h8000_0100 + 32'(4 * issued);
                end else begin
                    icb_cmd_valid = 1'b0;
                    scramble_cmd();
                end
            end
            icb_cmd_valid = 1'b0;
            check("st_issued", 32'(issued), 32'd16);
            check("st_got", 32'(got), 32'd16);
            check("st_stalls", 32'(stalls), 32'd0);
            check("st_first_rsp", 32'(first_rsp), 32'd1);
            check("st_last_rsp", 32'(last_rsp), 32'd16);
        end

        // Reset with two responses outstanding
        icb_rsp_ready = 1'b0;
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = 1'b1;
        icb_cmd_addr  = 32'h8000_0010;
        tick();
        icb_cmd_addr  = 32'h8000_0014;
        tick();
        icb_cmd_valid = 1'b0;
        check("mr_pre_valid", 32'(icb_rsp_valid), 32'd1);
        check("mr_pre_ready", 32'(icb_cmd_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mr_valid", 32'(icb_rsp_valid), 32'd0);
        check("mr_cmd_ready", 32'(icb_cmd_ready), 32'd1);
        check("mr_err", 32'(icb_rsp_err), 32'd0);
        check("mr_rdata", icb_rsp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        icb_rsp_ready = 1'b1;
        tick();
        check("mr_post_ready", 32'(icb_cmd_ready), 32'd1);
        check("mr_post_valid", 32'(icb_rsp_valid), 32'd0);
        single("mr_rd10", 32'h8000_0010, 1'b1, 32'h0, 4'h0, 1'b0, w10);
        single("mr_rd14", 32'h8000_0014, 1'b1, 32'h0, 4'h0, 1'b0, 32'h55AA_55AA);

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_e203_mem_icb_resp
